// File: rtl/lcd_spi_pkg.sv
// Shared opcodes, decoder states and window defaults for the LCD SPI sink.
// Build option LCD_SPI_SYNC_EN adds a two-flop input synchronizer.
package lcd_spi_pkg;

  localparam logic [7:0] SLPIN   = 8'h10;
  localparam logic [7:0] SLPOUT  = 8'h11;
  localparam logic [7:0] DISPOFF = 8'h28;
  localparam logic [7:0] DISPON  = 8'h29;
  localparam logic [7:0] CASET   = 8'h2A;
  localparam logic [7:0] RASET   = 8'h2B;
  localparam logic [7:0] RAMWR   = 8'h2C;

  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR,
    ST_PARAMS
  } state_t;

  function automatic logic [7:0] win_end(input int n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// Link sampler and MSB-first byte framer for the LCD SPI sink.
// Define LCD_SPI_SYNC_EN for an asynchronous initiator (two extra flops).
module lcd_spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       mosi,
  input  logic       cs,
  input  logic       dc,
  input  logic       lrst,
  output logic       soft_rst,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       frame_err
);

  // Idle pattern {scl,mosi,cs,dc,lrst}: no false edge on reset release.
  localparam logic [4:0] IDLE_PAT = 5'b10101;

  logic [4:0] in_w;
  logic       scl_q, mosi_q, cs_q, dc_q, lrst_q;
  logic       scl_prev;
  logic       scl_rise;
  logic [6:0] shift;
  logic [2:0] cnt;

`ifdef LCD_SPI_SYNC_EN
  logic [4:0] s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= IDLE_PAT;
      s2 <= IDLE_PAT;
    end else begin
      s1 <= {scl, mosi, cs, dc, lrst};
      s2 <= s1;
    end
  end

  assign in_w = s2;
`else
  assign in_w = {scl, mosi, cs, dc, lrst};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_q, mosi_q, cs_q, dc_q, lrst_q} <= IDLE_PAT;
      scl_prev <= 1'b1;
    end else begin
      {scl_q, mosi_q, cs_q, dc_q, lrst_q} <= in_w;
      scl_prev <= scl_q;
    end
  end

  assign scl_rise = scl_q & ~scl_prev & ~cs_q;
  assign soft_rst = ~lrst_q;

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      cnt   <= 3'd0;
      shift <= 7'd0;
    end else if (cs_q) begin
      cnt <= 3'd0;
    end else if (scl_rise) begin
      shift <= {shift[5:0], mosi_q};
      cnt   <= cnt + 3'd1;
    end
  end

  assign byte_done = scl_rise & (cnt == 3'd7);
  assign byte_data = {shift, mosi_q};
  assign byte_dc   = dc_q;
  assign frame_err = cs_q & (cnt != 3'd0);

endmodule

// File: rtl/lcd_spi_sink.sv
// ST7735 command/pixel decoder behind the LCD SPI byte framer.
// Build option LCD_SPI_SYNC_EN (see lcd_spi_byte_rx) adds input sync.
module lcd_spi_sink
  import lcd_spi_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCL,
  input  logic        MOSI,
  input  logic        CS,
  input  logic        DC,
  input  logic        LRST,
  output logic        CMD_VALID,
  output logic [7:0]  CMD,
  output logic        PARAM_VALID,
  output logic [7:0]  PARAM,
  output logic [3:0]  PARAM_IDX,
  output logic        PIX_VALID,
  output logic [15:0] PIX_DATA,
  output logic [7:0]  PIX_X,
  output logic [7:0]  PIX_Y,
  output logic        SLEEP_OUT,
  output logic        DISP_ON,
  output logic        FRAME_ERR
);

  logic       soft_rst;
  logic       byte_done;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       frame_err;

  state_t     state;
  logic [3:0] idx;
  logic [7:0] xs, xe, ys, ye;
  logic [7:0] x, y;
  logic       half;
  logic [7:0] hold;

  lcd_spi_byte_rx u_rx (
    .clk       (CLK),
    .rst       (RESET),
    .scl       (SCL),
    .mosi      (MOSI),
    .cs        (CS),
    .dc        (DC),
    .lrst      (LRST),
    .soft_rst  (soft_rst),
    .byte_done (byte_done),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .frame_err (frame_err)
  );

  always_ff @(posedge CLK) begin
    if (RESET || soft_rst) begin
      state       <= ST_IDLE;
      idx         <= 4'd0;
      xs          <= 8'd0;
      xe          <= win_end(WIDTH);
      ys          <= 8'd0;
      ye          <= win_end(HEIGHT);
      x           <= 8'd0;
      y           <= 8'd0;
      half        <= 1'b0;
      hold        <= 8'd0;
      CMD_VALID   <= 1'b0;
      CMD         <= 8'd0;
      PARAM_VALID <= 1'b0;
      PARAM       <= 8'd0;
      PARAM_IDX   <= 4'd0;
      PIX_VALID   <= 1'b0;
      PIX_DATA    <= 16'd0;
      PIX_X       <= 8'd0;
      PIX_Y       <= 8'd0;
      SLEEP_OUT   <= 1'b0;
      DISP_ON     <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      CMD_VALID   <= 1'b0;
      PARAM_VALID <= 1'b0;
      PIX_VALID   <= 1'b0;
      FRAME_ERR   <= frame_err;
      if (byte_done && !byte_dc) begin
        CMD_VALID <= 1'b1;
        CMD       <= byte_data;
        PARAM_IDX <= 4'd0;
        idx       <= 4'd0;
        half      <= 1'b0;
        case (byte_data)
          CASET:   state <= ST_CASET;
          RASET:   state <= ST_RASET;
          RAMWR: begin
            state <= ST_RAMWR;
            x     <= xs;
            y     <= ys;
          end
          default: state <= ST_PARAMS;
        endcase
        if (byte_data == SLPOUT)  SLEEP_OUT <= 1'b1;
        if (byte_data == SLPIN)   SLEEP_OUT <= 1'b0;
        if (byte_data == DISPON)  DISP_ON   <= 1'b1;
        if (byte_data == DISPOFF) DISP_ON   <= 1'b0;
      end else if (byte_done && state == ST_RAMWR) begin
        if (!half) begin
          hold <= byte_data;
          half <= 1'b1;
        end else begin
          half      <= 1'b0;
          PIX_VALID <= 1'b1;
          PIX_DATA  <= {hold, byte_data};
          PIX_X     <= x;
          PIX_Y     <= y;
          // 8-bit wrap lets a start beyond the end roll through 255
          if (x == xe) begin
            x <= xs;
            y <= (y == ye) ? ys : y + 8'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
      end else if (byte_done) begin
        PARAM_VALID <= 1'b1;
        PARAM       <= byte_data;
        PARAM_IDX   <= idx;
        idx         <= (idx == 4'd15) ? idx : idx + 4'd1;
        if (state == ST_CASET) begin
          if (idx == 4'd1) xs <= byte_data;
          if (idx == 4'd3) begin
            xe    <= byte_data;
            state <= ST_PARAMS;
          end
        end
        if (state == ST_RASET) begin
          if (idx == 4'd1) ys <= byte_data;
          if (idx == 4'd3) begin
            ye    <= byte_data;
            state <= ST_PARAMS;
          end
        end
      end
    end
  end

endmodule
